register_bank: RTL and testbench
================================

Name: register_bank

Overview:
- Parametrised general-purpose register file for the MIPS-style datapath; successor to the fixed 2-read/1-write, 32x32 register block.
- Adds:
  - configurable width, depth and read-port count;
  - write enable;
  - hardwired-zero register;
  - optional write-to-read bypass;
  - optional registered (1-cycle) read latency for the pipelined core.
- Sits between instruction decode (read addresses) and writeback (write port).

Parameters:
DATA_WIDTH, 32, bits per register
NUM_REGS, 32, number of registers (2..64, need not be a power of 2)
NUM_READ_PORTS, 2, independent read ports (1..4)
READ_LATENCY, 0, 0 = combinational read, 1 = registered read
BYPASS, 1, 1 = same-cycle write is visible on a read of the same address
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- readRegister  input  NUM_READ_PORTS*ADDR_WIDTH
  - read addresses, port p at bits [p*ADDR_WIDTH +: ADDR_WIDTH]
  - ADDR_WIDTH = clog2(NUM_REGS), minimum 1
- readData  output  NUM_READ_PORTS*DATA_WIDTH  read data, port p at bits [p*DATA_WIDTH +: DATA_WIDTH]
- writeEnable  input  1  commit writeData at the next rising edge
- writeRegister  input  ADDR_WIDTH  write address
- writeData  input  DATA_WIDTH  data to write

Behaviour:
- Reset: clock and reset form the only clock domain; reset is synchronous and active-high.
  - Reset asserted at an edge: every register becomes 0.
  - With READ_LATENCY=1, every readData pipeline register becomes 0.
  - A write presented in a reset cycle is dropped; reset wins.
  - readData under READ_LATENCY=0 follows the cleared storage in the cycle after reset.
- Write: at a rising edge with writeEnable=1 and reset=0, writeData is stored at writeRegister.
  - The write is ignored if writeRegister >= NUM_REGS.
  - The write is ignored if ZERO_REG=1 and writeRegister==0.
- Read, READ_LATENCY=0:
  - readData[p] is combinational from readRegister[p].
  - BYPASS=1: if writeEnable=1 and writeRegister==readRegister[p] and the write is legal (not reg 0 when ZERO_REG, in range), readData[p]=writeData in the same cycle.
  - BYPASS=0: readData[p] shows the old stored value until the edge.
- Read, READ_LATENCY=1:
  - readRegister[p] is sampled at the edge; readData[p] is valid after that edge and held until the next edge.
  - On a same-edge legal write to the same address:
    - BYPASS=1: readData[p] = new writeData;
    - BYPASS=0: readData[p] = pre-write value.
- Zero register: when ZERO_REG=1, a read of address 0 returns 0 on every port, regardless of bypass.
- Out-of-range read (address >= NUM_REGS): returns 0.
- Multiple ports may read the same address in one cycle; each port is independent.
- No X propagation: storage is reset, so every output is defined from the first post-reset cycle.
- Elaboration errors:
  - NUM_REGS < 2 or NUM_REGS > 64;
  - NUM_READ_PORTS outside 1..4;
  - READ_LATENCY not in {0,1}.

Decomposition:
- Package regfile_pkg:
  - DEFAULT_DATA_WIDTH=32, DEFAULT_NUM_REGS=32;
  - function addr_width(n) returning max(1, clog2(n));
  - localparam ZERO_ADDR=0.
- Sub-module register_bank_read_port, one instance per port via a generate loop. It contains:
  - address decode;
  - zero and out-of-range masking;
  - the bypass comparison;
  - the optional output register.
- Storage array and write logic stay in register_bank.

Test Plan:
1. Reset clears all registers: default params, write 0xDEADBEEF to r5, assert reset 1 cycle, read r5 on both ports -> 0x00000000 on both.
2. Zero register: write 0x12345678 to r0 (writeEnable=1), read r0 -> 0; write 0x0000ABCD to r31, read r31 -> 0x0000ABCD.
3. Bypass, latency 0:
   - BYPASS=1: write 0xCAFEF00D to r7 while readRegister port0=7 -> readData0=0xCAFEF00D in the same cycle.
   - BYPASS=0, same stimulus -> readData0 shows the previous r7 value, and 0xCAFEF00D on the following cycle.
4. Latency 1 pipeline:
   - READ_LATENCY=1, r3=0x11, r4=0x22; present addresses 3/4 at edge N -> readData0=0x11, readData1=0x22 after edge N, held through edge N+1 while addresses change.
   - Same-edge write of 0x33 to r3 -> 0x33 with BYPASS=1, 0x11 with BYPASS=0.
5. Write during reset: reset=1 and writeEnable=1 to r9 with 0xFF in the same cycle; release reset -> r9 reads 0.
6. Generalised config: NUM_REGS=24, NUM_READ_PORTS=3, DATA_WIDTH=16.
   - Write 0xBEEF to r23, write to r30 (out of range).
   - Read 23/30/23 -> 0xBEEF / 0x0000 / 0xBEEF.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register_bank slice.
//   DEFAULT_DATA_WIDTH / DEFAULT_NUM_REGS : defaults of the classic 32x32 block
//   ZERO_ADDR                             : address of the hardwired-zero register
//   addr_width(n)                         : address bits for n registers, never below 1
package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_REGS   = 32;
  localparam int ZERO_ADDR          = 0;

  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/register_bank_if.sv
// Bus between decode/writeback and the register bank.
//   readRegister  : packed read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   readData      : packed read data,      port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   writeEnable   : commit writeData to writeRegister at the next rising edge
//   writeRegister : write address
//   writeData     : write data
// Transfer rules: there is no valid/ready pair. A write is a single-cycle
// command qualified only by writeEnable (the bank never back-pressures), and
// every read port is always valid: readData is defined in every post-reset
// cycle for whatever address is presented.
interface register_bank_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS       = DEFAULT_NUM_REGS,
  parameter int NUM_READ_PORTS = 2
);
  localparam int ADDR_WIDTH = addr_width(NUM_REGS);

  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] readRegister;
  logic [NUM_READ_PORTS*DATA_WIDTH-1:0] readData;
  logic                                 writeEnable;
  logic [ADDR_WIDTH-1:0]                writeRegister;
  logic [DATA_WIDTH-1:0]                writeData;

  modport master (
    output readRegister, writeEnable, writeRegister, writeData,
    input  readData
  );

  modport slave (
    input  readRegister, writeEnable, writeRegister, writeData,
    output readData
  );
endinterface

// File: rtl/register_bank_read_port.sv
// One read port of the register bank.
//   clock, reset : shared clock domain, synchronous active-high reset
//   regs         : current contents of the storage array
//   addr         : read address of this port
//   write_legal  : a write is being committed this cycle (in range, not reg 0)
//   write_addr   : address of that write
//   write_data   : data of that write
//   data         : read result (combinational or registered by READ_LATENCY)
module register_bank_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS     = DEFAULT_NUM_REGS,
  parameter int ADDR_WIDTH   = addr_width(DEFAULT_NUM_REGS),
  parameter int READ_LATENCY = 0,
  parameter int BYPASS       = 1,
  parameter int ZERO_REG     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] regs [NUM_REGS],
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  write_legal,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] data
);

  // One extra bit so NUM_REGS=64 with a 6-bit address still compares correctly.
  localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH+1)'(NUM_REGS);

  logic                  in_range;
  logic                  is_zero;
  logic                  bypass_hit;
  logic [DATA_WIDTH-1:0] data_next;
  logic [DATA_WIDTH-1:0] data_q;

  assign in_range   = ({1'b0, addr} < REG_LIMIT);
  assign is_zero    = (ZERO_REG != 0) && (addr == ADDR_WIDTH'(ZERO_ADDR));
  // write_legal already excludes reg 0 and out-of-range writes, so a hit can
  // never leak data onto a masked address.
  assign bypass_hit = (BYPASS != 0) && write_legal && (write_addr == addr);

  always_comb begin
    data_next = '0;
    if (in_range && !is_zero) begin
      data_next = bypass_hit ? write_data : regs[addr];
    end
  end

  // Sampling data_next at the edge gives the bypassed (new) value with
  // BYPASS=1 and the pre-write storage value with BYPASS=0.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_next;
    end
  end

  assign data = (READ_LATENCY != 0) ? data_q : data_next;

endmodule

// File: rtl/register_bank.sv
// Parametrised general-purpose register file for the MIPS-style datapath.
//   clock : single clock, rising edge
//   reset : synchronous, active-high; clears storage and read pipelines
//   bus   : register_bank_if slave (read addresses/data, write port)
// Storage and write logic live here; each read port is a
// register_bank_read_port instance.
module register_bank
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS       = DEFAULT_NUM_REGS,
  parameter int NUM_READ_PORTS = 2,
  parameter int READ_LATENCY   = 0,
  parameter int BYPASS         = 1,
  parameter int ZERO_REG       = 1
) (
  input logic            clock,
  input logic            reset,
  register_bank_if.slave bus
);

  localparam int ADDR_WIDTH = addr_width(NUM_REGS);
  localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH+1)'(NUM_REGS);

  if (NUM_REGS < 2 || NUM_REGS > 64) begin : g_bad_num_regs
    $error("register_bank: NUM_REGS must be in 2..64");
  end
  if (NUM_READ_PORTS < 1 || NUM_READ_PORTS > 4) begin : g_bad_num_ports
    $error("register_bank: NUM_READ_PORTS must be in 1..4");
  end
  if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : g_bad_latency
    $error("register_bank: READ_LATENCY must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0]                regs [NUM_REGS];
  logic                                 write_in_range;
  logic                                 write_to_zero;
  logic                                 write_legal;
  logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data;

  assign write_in_range = ({1'b0, bus.writeRegister} < REG_LIMIT);
  assign write_to_zero  = (ZERO_REG != 0) && (bus.writeRegister == ADDR_WIDTH'(ZERO_ADDR));
  assign write_legal    = bus.writeEnable && write_in_range && !write_to_zero;

  // Reset has priority, so a write presented in a reset cycle is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_legal) begin
      regs[bus.writeRegister] <= bus.writeData;
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_read_port
    register_bank_read_port #(
      .DATA_WIDTH  (DATA_WIDTH),
      .NUM_REGS    (NUM_REGS),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .READ_LATENCY(READ_LATENCY),
      .BYPASS      (BYPASS),
      .ZERO_REG    (ZERO_REG)
    ) u_read_port (
      .clock      (clock),
      .reset      (reset),
      .regs       (regs),
      .addr       (bus.readRegister[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .write_legal(write_legal),
      .write_addr (bus.writeRegister),
      .write_data (bus.writeData),
      .data       (read_data[p*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign bus.readData = read_data;

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank. Five configurations run side by side on
// one clock/reset:
//   u_a : defaults (32x32, 2 ports, latency 0, bypass on)
//   u_b : latency 0, bypass off
//   u_c : latency 1, bypass on
//   u_d : latency 1, bypass off
//   u_e : 24 regs, 3 ports, 16-bit data, latency 0, bypass on
// Inputs change on the falling edge; outputs are checked #1 later or on the
// following falling edge, away from the rising edge.
module tb_register_bank;

  logic clock;
  logic reset;

  int n_checks;
  int n_fail;

  register_bank_if #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ_PORTS(2)) if_a ();
  register_bank_if #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ_PORTS(2)) if_b ();
  register_bank_if #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ_PORTS(2)) if_c ();
  register_bank_if #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ_PORTS(2)) if_d ();
  register_bank_if #(.DATA_WIDTH(16), .NUM_REGS(24), .NUM_READ_PORTS(3)) if_e ();

  register_bank #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ_PORTS(2),
                  .READ_LATENCY(0), .BYPASS(1), .ZERO_REG(1))
    u_a (.clock(clock), .reset(reset), .bus(if_a));
  register_bank #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ_PORTS(2),
                  .READ_LATENCY(0), .BYPASS(0), .ZERO_REG(1))
    u_b (.clock(clock), .reset(reset), .bus(if_b));
  register_bank #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ_PORTS(2),
                  .READ_LATENCY(1), .BYPASS(1), .ZERO_REG(1))
    u_c (.clock(clock), .reset(reset), .bus(if_c));
  register_bank #(.DATA_WIDTH(32), .NUM_REGS(32), .NUM_READ_PORTS(2),
                  .READ_LATENCY(1), .BYPASS(0), .ZERO_REG(1))
    u_d (.clock(clock), .reset(reset), .bus(if_d));
  register_bank #(.DATA_WIDTH(16), .NUM_REGS(24), .NUM_READ_PORTS(3),
                  .READ_LATENCY(0), .BYPASS(1), .ZERO_REG(1))
    u_e (.clock(clock), .reset(reset), .bus(if_e));

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;

    if_a.readRegister = '0; if_a.writeEnable = 1'b0; if_a.writeRegister = '0; if_a.writeData = '0;
    if_b.readRegister = '0; if_b.writeEnable = 1'b0; if_b.writeRegister = '0; if_b.writeData = '0;
    if_c.readRegister = '0; if_c.writeEnable = 1'b0; if_c.writeRegister = '0; if_c.writeData = '0;
    if_d.readRegister = '0; if_d.writeEnable = 1'b0; if_d.writeRegister = '0; if_d.writeData = '0;
    if_e.readRegister = '0; if_e.writeEnable = 1'b0; if_e.writeRegister = '0; if_e.writeData = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset_a_port0", if_a.readData[31:0], 32'h0);
    check("reset_c_port0", if_c.readData[31:0], 32'h0);
    check("reset_e_all",   {16'h0, if_e.readData[47:32] | if_e.readData[31:16] | if_e.readData[15:0]}, 32'h0);

    // Test 1/5: load values, then reset while a write to r9 is presented.
    @(negedge clock);
    if_a.writeEnable = 1'b1; if_a.writeRegister = 5'd5; if_a.writeData = 32'hDEADBEEF;
    if_c.writeEnable = 1'b1; if_c.writeRegister = 5'd2; if_c.writeData = 32'h00000055;
    if_c.readRegister = {5'd0, 5'd2};
    @(negedge clock);
    if_a.writeEnable = 1'b0; if_a.readRegister = {5'd5, 5'd5};
    if_c.writeEnable = 1'b0;
    #1;
    check("t1_r5_port0_loaded", if_a.readData[31:0],  32'hDEADBEEF);
    check("t1_r5_port1_loaded", if_a.readData[63:32], 32'hDEADBEEF);
    check("t1_c_r2_loaded",     if_c.readData[31:0],  32'h00000055);
    reset = 1'b1;
    if_a.writeEnable = 1'b1; if_a.writeRegister = 5'd9; if_a.writeData = 32'h000000FF;
    @(negedge clock);
    reset = 1'b0;
    if_a.writeEnable = 1'b0; if_a.readRegister = {5'd9, 5'd5};
    #1;
    check("t1_r5_after_reset",      if_a.readData[31:0],  32'h0);
    check("t5_r9_write_in_reset",   if_a.readData[63:32], 32'h0);
    check("t1_c_pipe_after_reset",  if_c.readData[31:0],  32'h0);

    // Test 2: zero register ignores writes, no bypass onto r0.
    @(negedge clock);
    if_a.writeEnable = 1'b1; if_a.writeRegister = 5'd0; if_a.writeData = 32'h12345678;
    if_a.readRegister = {5'd0, 5'd0};
    #1;
    check("t2_r0_bypass_masked", if_a.readData[31:0], 32'h0);
    @(negedge clock);
    if_a.writeEnable = 1'b1; if_a.writeRegister = 5'd31; if_a.writeData = 32'h0000ABCD;
    if_a.readRegister = {5'd31, 5'd0};
    #1;
    check("t2_r0_after_write",  if_a.readData[31:0],  32'h0);
    check("t2_r31_bypass",      if_a.readData[63:32], 32'h0000ABCD);
    @(negedge clock);
    if_a.writeEnable = 1'b0;
    #1;
    check("t2_r31_stored",      if_a.readData[63:32], 32'h0000ABCD);

    // Test 3: latency-0 bypass on (a) and off (b). r7 first holds 0x77.
    @(negedge clock);
    if_a.writeEnable = 1'b1; if_a.writeRegister = 5'd7; if_a.writeData = 32'h00000077;
    if_b.writeEnable = 1'b1; if_b.writeRegister = 5'd7; if_b.writeData = 32'h00000077;
    @(negedge clock);
    if_a.writeData = 32'hCAFEF00D; if_a.readRegister = {5'd0, 5'd7};
    if_b.writeData = 32'hCAFEF00D; if_b.readRegister = {5'd0, 5'd7};
    #1;
    check("t3_bypass_on_same_cycle",  if_a.readData[31:0], 32'hCAFEF00D);
    check("t3_bypass_off_same_cycle", if_b.readData[31:0], 32'h00000077);
    @(negedge clock);
    if_a.writeEnable = 1'b0;
    if_b.writeEnable = 1'b0;
    #1;
    check("t3_bypass_on_next_cycle",  if_a.readData[31:0], 32'hCAFEF00D);
    check("t3_bypass_off_next_cycle", if_b.readData[31:0], 32'hCAFEF00D);

    // Test 4: latency-1 pipeline on c (bypass) and d (no bypass).
    @(negedge clock);
    if_c.writeEnable = 1'b1; if_c.writeRegister = 5'd3; if_c.writeData = 32'h00000011;
    if_d.writeEnable = 1'b1; if_d.writeRegister = 5'd3; if_d.writeData = 32'h00000011;
    @(negedge clock);
    if_c.writeRegister = 5'd4; if_c.writeData = 32'h00000022;
    if_d.writeRegister = 5'd4; if_d.writeData = 32'h00000022;
    @(negedge clock);
    if_c.writeEnable = 1'b0; if_c.readRegister = {5'd4, 5'd3};
    if_d.writeEnable = 1'b0; if_d.readRegister = {5'd4, 5'd3};
    @(negedge clock);
    check("t4_c_port0_after_edge", if_c.readData[31:0],  32'h00000011);
    check("t4_c_port1_after_edge", if_c.readData[63:32], 32'h00000022);
    check("t4_d_port0_after_edge", if_d.readData[31:0],  32'h00000011);
    check("t4_d_port1_after_edge", if_d.readData[63:32], 32'h00000022);
    if_c.readRegister = {5'd1, 5'd2};
    if_d.readRegister = {5'd1, 5'd2};
    #1;
    check("t4_c_port0_held", if_c.readData[31:0],  32'h00000011);
    check("t4_c_port1_held", if_c.readData[63:32], 32'h00000022);
    @(negedge clock);
    check("t4_c_port0_new_addr", if_c.readData[31:0],  32'h0);
    check("t4_c_port1_new_addr", if_c.readData[63:32], 32'h0);
    if_c.writeEnable = 1'b1; if_c.writeRegister = 5'd3; if_c.writeData = 32'h00000033;
    if_d.writeEnable = 1'b1; if_d.writeRegister = 5'd3; if_d.writeData = 32'h00000033;
    if_c.readRegister = {5'd1, 5'd3};
    if_d.readRegister = {5'd1, 5'd3};
    @(negedge clock);
    check("t4_c_same_edge_bypass",    if_c.readData[31:0], 32'h00000033);
    check("t4_d_same_edge_no_bypass", if_d.readData[31:0], 32'h00000011);
    if_c.writeEnable = 1'b0;
    if_d.writeEnable = 1'b0;
    @(negedge clock);
    check("t4_d_after_write", if_d.readData[31:0], 32'h00000033);

    // Test 6: 24 regs, 3 ports, 16-bit data; r30 is out of range.
    @(negedge clock);
    if_e.writeEnable = 1'b1; if_e.writeRegister = 5'd23; if_e.writeData = 16'hBEEF;
    @(negedge clock);
    if_e.writeRegister = 5'd30; if_e.writeData = 16'h1234;
    if_e.readRegister = {5'd0, 5'd30, 5'd0};
    #1;
    check("t6_oor_no_bypass", {16'h0, if_e.readData[31:16]}, 32'h0);
    @(negedge clock);
    if_e.writeEnable = 1'b0;
    if_e.readRegister = {5'd23, 5'd30, 5'd23};
    #1;
    check("t6_port0_r23", {16'h0, if_e.readData[15:0]},  32'h0000BEEF);
    check("t6_port1_r30", {16'h0, if_e.readData[31:16]}, 32'h0);
    check("t6_port2_r23", {16'h0, if_e.readData[47:32]}, 32'h0000BEEF);
    @(negedge clock);
    if_e.readRegister = {5'd22, 5'd6, 5'd0};
    #1;
    check("t6_r6_not_aliased",  {16'h0, if_e.readData[31:16]}, 32'h0);
    check("t6_r22_untouched",   {16'h0, if_e.readData[47:32]}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
